wb_trace_buffer: RTL and testbench
==================================

// Module: wb_trace_buffer
// PURPOSE
//  Consumer end of the core's debug_WB_* write-back interface: captures every retired register
//  write (addr, data) with a cycle stamp into an on-chip FIFO, drained by a valid/ready reader.
//  Instantiated beside rv32IRJCore, so retirement is checked in RTL/FPGA without $monitor.
// PARAMETERS
//  DEPTH      16  FIFO entries; power of two, >= 2
//  STAMP_W    16  cycle-stamp width, bits
//  DROP_X0    1   1: writes with addr == 0 are not captured
//  CNT_W      8   drop-counter width, saturating
// PORTS
//  clk_i_core      in   1        core clock; the only clock
//  reset_i_core    in   1        asynchronous reset, active-low
//  wb_wrtEn_i      in   1        debug_WB_WrtEn from core
//  wb_wrtAddr_i    in   5        debug_WB_WrtAddr (`RegAddrBus)
//  wb_wrtData_i    in   32       debug_WB_WrtData (`RegDataBus)
//  capture_en_i    in   1        1: capture enabled; 0: commits ignored, not counted as drops
//  clear_i         in   1        synchronous flush of FIFO, flags and counters
//  trace_valid_o   out  1        head entry present
//  trace_ready_i   in   1        reader accepts head when trace_valid_o & trace_ready_i
//  trace_addr_o    out  5        head register address
//  trace_data_o    out  32       head write data
//  trace_stamp_o   out  STAMP_W  head cycle stamp
//  level_o         out  log2(DEPTH)+1  entries stored
//  overflow_o      out  1        sticky: >= 1 commit lost because FIFO full
//  drop_cnt_o      out  CNT_W    lost commits, saturates at all-ones
// BEHAVIOUR
//  Reset (reset_i_core low, async): FIFO empty; trace_valid_o=0; addr/data/stamp outputs 0;
//   level_o=0; overflow_o=0; drop_cnt_o=0; stamp counter=0. Release is synchronous to clk.
//  Stamp counter: increments every cycle after reset; wraps at 2^STAMP_W-1 -> 0; cleared by clear_i.
//  Push: at a rising edge when wb_wrtEn_i & capture_en_i & !(DROP_X0 & addr==0), entry
//   {addr,data,stamp} is written; stamp = counter value in that cycle.
//  Latency: commit sampled at edge N -> visible on trace_* after edge N (valid same cycle N+1)
//   if FIFO was empty; first-word-fall-through, outputs driven from head register/array.
//  Pop: on valid&ready at an edge, head advances; trace_* must not change while valid&!ready.
//  Full: push when level==DEPTH and no pop in same cycle -> entry discarded, overflow_o<=1,
//   drop_cnt_o+=1 (saturating). Push+pop on the same edge while full: both happen, no drop.
//  Empty: ready ignored when trace_valid_o=0; push+pop while empty impossible (valid=0).
//  Push+pop same edge, non-empty: level_o unchanged; order strictly preserved.
//  Pointers: log2(DEPTH)+1 bits, wrap naturally; full = MSBs differ & rest equal.
//  clear_i: highest priority over push/pop in that cycle; FIFO empty, flags/counters/stamp 0.
//  Reset mid-drain: contents lost, no partial entry ever presented.
//  No state machine beyond FIFO control; all outputs registered or from FIFO storage only.
// STRUCTURE
//  Shared defines header: `RegAddrBus, `RegDataBus (existing); add `TraceStampBus and
//   `TRACE_DEPTH default there.
//  One sub-module: trace_fifo (generic sync FIFO, WIDTH/DEPTH params, push/pop/full/empty/level,
//   async active-low reset); top adds filtering, stamp counter, overflow/drop logic.
// TESTING
//  1 reset low 3 cycles, release; commit x5=0x0000_002A at stamp 4 -> next cycle valid=1,
//    addr=5, data=0x2A, stamp=4; ready=1 -> valid=0, level_o=0.
//  2 DROP_X0=1: commit x0=0xFFFF_FFFF then x1=0x1 -> only x1 appears; drop_cnt_o=0.
//  3 ready=0, 20 commits x1..x20 data=i, DEPTH=16 -> level_o=16, overflow_o=1, drop_cnt_o=4;
//    drain -> data 1..16 in order; flag stays 1 until clear_i.
//  4 FIFO full, commit + pop same edge -> no drop, level_o stays 16, new entry last out.
//  5 ready=0 with entry held 5 cycles -> trace_* stable; capture_en_i=0 commits -> level unchanged.
//  6 reset_i_core low async mid-burst (level 7) -> all outputs 0 immediately, before next edge;
//    clear_i with push on same edge -> level_o=0, stamp restarts at 0.

Source files
------------

// File: rtl/wb_trace_buffer_pkg.sv
// Shared trace-buffer definitions: register bus macros, defaults and the capture filter.
`ifndef WB_TRACE_DEFINES
`define WB_TRACE_DEFINES
`define RegAddrBus    4:0
`define RegDataBus    31:0
`define TraceStampBus 15:0
`define TRACE_DEPTH   16
`endif

package wb_trace_buffer_pkg;
    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    // x0 is hardwired to zero, so its writes carry no information when filtering is on.
    function automatic logic keep_commit(input logic drop_x0, input logic [REG_AW-1:0] addr);
        return !(drop_x0 && (addr == '0));
    endfunction
endpackage

// File: rtl/trace_fifo.sv
// Generic first-word-fall-through synchronous FIFO with extra-MSB pointers.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty && !clr;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop) && !clr;

    // Head is masked while empty so stale storage never reaches the reader.
    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/wb_trace_buffer.sv
// Captures retired register writes with a cycle stamp into a FIFO drained by a valid/ready reader.
module wb_trace_buffer
    import wb_trace_buffer_pkg::*;
#(
    parameter int DEPTH   = `TRACE_DEPTH,
    parameter int STAMP_W = 16,
    parameter bit DROP_X0 = 1'b1,
    parameter int CNT_W   = 8
) (
    input  logic                     clk_i_core,
    input  logic                     reset_i_core,
    input  logic                     wb_wrtEn_i,
    input  logic [`RegAddrBus]       wb_wrtAddr_i,
    input  logic [`RegDataBus]       wb_wrtData_i,
    input  logic                     capture_en_i,
    input  logic                     clear_i,
    output logic                     trace_valid_o,
    input  logic                     trace_ready_i,
    output logic [`RegAddrBus]       trace_addr_o,
    output logic [`RegDataBus]       trace_data_o,
    output logic [STAMP_W-1:0]       trace_stamp_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         drop_cnt_o
);
    localparam int EW = REG_AW + REG_DW + STAMP_W;

    logic [STAMP_W-1:0] stamp_q;
    logic               want_push, pop, full, empty, push, drop;
    logic [EW-1:0]      head;

    assign want_push = wb_wrtEn_i && capture_en_i && keep_commit(DROP_X0, wb_wrtAddr_i);
    assign pop       = trace_valid_o && trace_ready_i;
    assign push      = want_push;
    assign drop      = want_push && full && !pop;

    trace_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk_i_core),
        .rst_n (reset_i_core),
        .clr   (clear_i),
        .push  (push),
        .din   ({wb_wrtAddr_i, wb_wrtData_i, stamp_q}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level_o)
    );

    assign trace_valid_o = !empty;
    assign {trace_addr_o, trace_data_o, trace_stamp_o} = head;

    always_ff @(posedge clk_i_core or negedge reset_i_core) begin
        if (!reset_i_core) begin
            stamp_q    <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (clear_i) begin
            stamp_q    <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            stamp_q <= stamp_q + STAMP_W'(1);
            if (drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed and randomized checks of wb_trace_buffer against a queue-based reference model.
module tb_wb_trace_buffer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n, wb_en, cap, clr, rdy;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        t_valid, t_ovf;
    logic [4:0]  t_addr;
    logic [31:0] t_data;
    logic [15:0] t_stamp;
    logic [4:0]  t_level;
    logic [7:0]  t_drop;

    int errs = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [15:0] s;
    } ent_t;

    ent_t q[$];
    int   m_stamp;
    bit   m_ovf;
    int   m_drop;

    always #5 clk = ~clk;

    wb_trace_buffer dut (
        .clk_i_core    (clk),
        .reset_i_core  (rst_n),
        .wb_wrtEn_i    (wb_en),
        .wb_wrtAddr_i  (wb_addr),
        .wb_wrtData_i  (wb_data),
        .capture_en_i  (cap),
        .clear_i       (clr),
        .trace_valid_o (t_valid),
        .trace_ready_i (rdy),
        .trace_addr_o  (t_addr),
        .trace_data_o  (t_data),
        .trace_stamp_o (t_stamp),
        .level_o       (t_level),
        .overflow_o    (t_ovf),
        .drop_cnt_o    (t_drop)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic reset_model();
        q.delete();
        m_stamp = 0;
        m_ovf   = 0;
        m_drop  = 0;
    endtask

    // One clock edge of the reference: pop, then push or drop, then stamp advance.
    task automatic model_edge();
        bit do_pop, want;
        if (!rst_n || clr) begin
            reset_model();
        end else begin
            do_pop = rdy && (q.size() > 0);
            want   = wb_en && cap && (wb_addr != 0);
            if (do_pop) void'(q.pop_front());
            if (want) begin
                if (q.size() == DEPTH) begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end else begin
                    q.push_back('{a: wb_addr, d: wb_data, s: 16'(m_stamp)});
                end
            end
            m_stamp = (m_stamp + 1) % 65536;
        end
    endtask

    task automatic check_outputs();
        ent_t h;
        h = '{a: 5'd0, d: 32'd0, s: 16'd0};
        if (q.size() > 0) h = q[0];
        chk("valid", t_valid, (q.size() > 0));
        chk("addr",  t_addr,  h.a);
        chk("data",  t_data,  h.d);
        chk("stamp", t_stamp, h.s);
        chk("level", t_level, q.size());
        chk("ovf",   t_ovf,   m_ovf);
        chk("drop",  t_drop,  m_drop);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic commit(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 0;
    endtask

    task automatic async_reset_check();
        #2;
        rst_n = 0;
        #1;
        reset_model();
        chk("arst_valid", t_valid, 0);
        chk("arst_level", t_level, 0);
        chk("arst_data",  {t_addr, t_data, t_stamp}, 0);
        chk("arst_flags", {t_ovf, t_drop}, 0);
    endtask

    initial begin
        logic [52:0] held;
        int rprob;
        rst_n = 0; wb_en = 0; wb_addr = 0; wb_data = 0; cap = 1; clr = 0; rdy = 0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1;

        // first capture and latency
        repeat (4) tick();
        commit(5'd5, 32'h2A);
        chk("t1_valid", t_valid, 1);
        chk("t1_addr",  t_addr, 5);
        chk("t1_data",  t_data, 32'h2A);
        chk("t1_stamp", t_stamp, 4);
        rdy = 1; tick(); rdy = 0;
        chk("t1_empty", {t_valid, t_level}, 0);

        // x0 filtered
        commit(5'd0, 32'hFFFF_FFFF);
        commit(5'd1, 32'h1);
        chk("t2_level", t_level, 1);
        chk("t2_addr",  t_addr, 1);
        chk("t2_drop",  t_drop, 0);
        rdy = 1; tick(); rdy = 0;

        // overflow
        for (int i = 1; i <= 20; i++) commit(5'(i), 32'(i));
        chk("t3_level", t_level, 16);
        chk("t3_ovf",   t_ovf, 1);
        chk("t3_drop",  t_drop, 4);

        // push + pop while full
        rdy = 1;
        commit(5'd21, 32'h99);
        chk("t4_level", t_level, 16);
        chk("t4_drop",  t_drop, 4);
        for (int i = 2; i <= 16; i++) begin
            chk("t3_drain", t_data, i);
            tick();
        end
        chk("t4_last", t_data, 32'h99);
        tick();
        rdy = 0;
        chk("t3_empty", t_valid, 0);
        chk("t3_sticky", t_ovf, 1);

        // hold stability and capture gating
        commit(5'd7, 32'h77);
        held = {t_addr, t_data, t_stamp};
        cap = 0;
        for (int i = 0; i < 5; i++) begin
            commit(5'($urandom_range(1, 31)), $urandom);
            chk("t5_hold", {t_addr, t_data, t_stamp}, held);
            chk("t5_level", t_level, 1);
        end
        cap = 1;

        // clear, async reset mid-burst, clear with push
        clr = 1; tick(); clr = 0;
        chk("t6_clr_ovf", t_ovf, 0);
        for (int i = 0; i < 7; i++) commit(5'(i + 1), $urandom);
        chk("t6_level7", t_level, 7);
        async_reset_check();
        tick(); tick();
        rst_n = 1;
        wb_en = 1; wb_addr = 3; wb_data = 32'h33; clr = 1;
        tick();
        clr = 0; wb_en = 0;
        chk("t6_clr_push", t_level, 0);
        commit(5'd4, 32'h44);
        chk("t6_stamp0", t_stamp, 0);
        rdy = 1; tick();

        // randomized traffic
        rprob = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) rprob = (n / 200 % 3 == 0) ? 10 : ((n / 200 % 3 == 1) ? 50 : 90);
            wb_en   = ($urandom_range(0, 99) < 70);
            wb_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wb_data = $urandom;
            cap     = ($urandom_range(0, 15) != 0);
            clr     = ($urandom_range(0, 149) == 0);
            rdy     = ($urandom_range(0, 99) < rprob);
            tick();
            if (!rst_n) rst_n = 1;
            else if ($urandom_range(0, 499) == 0) async_reset_check();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
